// File: rtl/audio_codec_rjm_slave_if.sv
// Parallel and serial signal bundle between a right-justified audio master
// and the codec-side slave.
interface audio_codec_rjm_slave_if #(
    parameter int WD = 24
);
    logic          en_i;
    logic          codec_bclk_i;
    logic          codec_lrck_i;
    logic          dac_serial_data_i;
    logic [WD-1:0] adc_left_i;
    logic [WD-1:0] adc_right_i;
    logic          adc_valid_i;
    logic          adc_serial_data_o;
    logic          adc_req_o;
    logic [WD-1:0] dac_left_o;
    logic [WD-1:0] dac_right_o;
    logic          dac_valid_o;
    logic          frame_err_o;

    modport slave (
        input  en_i, codec_bclk_i, codec_lrck_i, dac_serial_data_i,
        input  adc_left_i, adc_right_i, adc_valid_i,
        output adc_serial_data_o, adc_req_o, dac_left_o, dac_right_o,
        output dac_valid_o, frame_err_o
    );

    modport master (
        output en_i, codec_bclk_i, codec_lrck_i, dac_serial_data_i,
        output adc_left_i, adc_right_i, adc_valid_i,
        input  adc_serial_data_o, adc_req_o, dac_left_o, dac_right_o,
        input  dac_valid_o, frame_err_o
    );
endinterface

// File: rtl/audio_codec_rjm_slave.sv
// Right-justified codec slave: follows external bclk/lrck, serializes the ADC
// pair and deserializes the DAC line into a stereo pair.
module audio_codec_rjm_slave #(
    parameter int WD   = 24,
    parameter int SLOT = 32
) (
    input logic                    clk_i,
    input logic                    rst_ni,
    audio_codec_rjm_slave_if.slave bus
);
    localparam int              CW      = $clog2(SLOT);
    localparam int              IW      = (WD > 1) ? $clog2(WD) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(SLOT - 1);
    localparam logic [CW:0]     PAD_END = (CW+1)'(SLOT - WD);
    localparam logic [CW:0]     N_END   = (CW+1)'(SLOT);
    localparam logic [CW:0]     N_TOP   = (CW+1)'(SLOT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    // Bit n of a slot: leading padding zeros, then the word MSB first.
    function automatic logic tx_bit(input logic [WD-1:0] w, input logic [CW:0] n);
        if (n >= PAD_END && n < N_END) return w[IW'(N_TOP - n)];
        return 1'b0;
    endfunction

    logic r_bclk_p0, r_bclk_p1, r_bclk_p2;
    logic r_lrck_p0, r_lrck_p1;
    logic r_dat_p0, r_dat_p1;
    logic r_rise_p3, r_fall_p3, r_lrck_p3, r_dat_p3;

    // Stage p0/p1: two-flop synchronizers; p2: delayed bclk; p3: registered edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bclk_p0 <= 1'b0;
            r_bclk_p1 <= 1'b0;
            r_bclk_p2 <= 1'b0;
            r_lrck_p0 <= 1'b0;
            r_lrck_p1 <= 1'b0;
            r_dat_p0  <= 1'b0;
            r_dat_p1  <= 1'b0;
            r_rise_p3 <= 1'b0;
            r_fall_p3 <= 1'b0;
            r_lrck_p3 <= 1'b0;
            r_dat_p3  <= 1'b0;
        end else begin
            r_bclk_p0 <= bus.codec_bclk_i;
            r_bclk_p1 <= r_bclk_p0;
            r_bclk_p2 <= r_bclk_p1;
            r_lrck_p0 <= bus.codec_lrck_i;
            r_lrck_p1 <= r_lrck_p0;
            r_dat_p0  <= bus.dac_serial_data_i;
            r_dat_p1  <= r_dat_p0;
            r_rise_p3 <= r_bclk_p1 & ~r_bclk_p2;
            r_fall_p3 <= ~r_bclk_p1 & r_bclk_p2;
            r_lrck_p3 <= r_lrck_p1;
            r_dat_p3  <= r_dat_p1;
        end
    end

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lrck_prev;
    logic [WD-1:0] r_rx, r_stage;
    logic [WD-1:0] r_hold_l, r_hold_r, r_tx_l, r_tx_r;
    logic [WD-1:0] r_dac_l, r_dac_r;
    logic          r_sdo, r_req, r_dval, r_ferr;

    logic          w_bound, w_up, w_down, w_cnt_last, w_tx_bit;
    logic [CW:0]   w_n;
    logic [WD-1:0] w_word;

    assign w_bound    = r_rise_p3 && (r_lrck_p3 != r_lrck_prev);
    assign w_up       = w_bound && r_lrck_p3;
    assign w_down     = w_bound && !r_lrck_p3;
    assign w_cnt_last = (r_cnt == LAST);
    assign w_n        = {1'b0, r_cnt} + (CW+1)'(1);
    assign w_word     = r_lrck_prev ? r_tx_l : r_tx_r;
    assign w_tx_bit   = tx_bit(w_word, w_n);

    // Stage p4: slot tracking, word transfer and serial output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lrck_prev <= 1'b0;
            r_rx        <= '0;
            r_stage     <= '0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_tx_l      <= '0;
            r_tx_r      <= '0;
            r_dac_l     <= '0;
            r_dac_r     <= '0;
            r_sdo       <= 1'b0;
            r_req       <= 1'b0;
            r_dval      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_req  <= 1'b0;
            r_dval <= 1'b0;
            r_ferr <= 1'b0;
            if (bus.adc_valid_i) begin
                r_hold_l <= bus.adc_left_i;
                r_hold_r <= bus.adc_right_i;
            end
            // lrck history is kept even while idle so re-enabling mid-slot
            // cannot mistake the current level for a fresh boundary.
            if (r_rise_p3) r_lrck_prev <= r_lrck_p3;

            if (!bus.en_i) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_sdo   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SYNC;
                        r_sdo   <= 1'b0;
                    end
                    SYNC: begin
                        r_sdo <= 1'b0;
                        if (r_rise_p3) begin
                            r_rx  <= {r_rx[WD-2:0], r_dat_p3};
                            r_cnt <= w_bound ? '0 : r_cnt + CW'(1);
                            if (w_up) begin
                                r_state <= RUN;
                                r_tx_l  <= r_hold_l;
                                r_tx_r  <= r_hold_r;
                                r_req   <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (r_rise_p3) begin
                            r_rx <= {r_rx[WD-2:0], r_dat_p3};
                            if (w_bound) begin
                                r_cnt <= '0;
                                if (!w_cnt_last) begin
                                    r_ferr  <= 1'b1;
                                    r_state <= SYNC;
                                    r_stage <= '0;
                                    r_sdo   <= 1'b0;
                                end else if (w_down) begin
                                    r_stage <= r_rx;
                                end else begin
                                    r_dac_r <= r_rx;
                                    r_dac_l <= r_stage;
                                    r_dval  <= 1'b1;
                                    r_tx_l  <= r_hold_l;
                                    r_tx_r  <= r_hold_r;
                                    r_req   <= 1'b1;
                                end
                            end else if (w_cnt_last) begin
                                r_ferr  <= 1'b1;
                                r_state <= SYNC;
                                r_stage <= '0;
                                r_sdo   <= 1'b0;
                                r_cnt   <= r_cnt + CW'(1);
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end
                        if (r_fall_p3) r_sdo <= w_tx_bit;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.adc_serial_data_o = r_sdo;
    assign bus.adc_req_o         = r_req;
    assign bus.dac_left_o        = r_dac_l;
    assign bus.dac_right_o       = r_dac_r;
    assign bus.dac_valid_o       = r_dval;
    assign bus.frame_err_o       = r_ferr;
endmodule

// File: tb/tb_audio_codec_rjm_slave.sv
// Bench for audio_codec_rjm_slave: a master model drives bclk/lrck/DAC data,
// scoreboard queues hold expected DAC pairs and ADC slot patterns.
module tb_audio_codec_rjm_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_codec_rjm_slave_if #(.WD(24)) bus ();

    audio_codec_rjm_slave #(.WD(24), .SLOT(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } dac_pair_t;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] bits;
    } adc_exp_t;

    dac_pair_t exp_dac_q[$];
    adc_exp_t  exp_adc_q[$];

    int checks = 0;
    int errors = 0;
    int n_req = 0;
    int n_err = 0;
    int slot_no = 0;
    logic quiet = 1'b0;
    logic quiet_hi = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One half-frame: lrck level lr, DAC word right-justified in a 32-bit slot.
    task automatic half_slot(input logic lr, input logic [23:0] w, input int nbits,
                             input int en_at, input logic en_val);
        logic [31:0] f;
        f = {8'h00, w};
        slot_no++;
        for (int i = 0; i < nbits; i++) begin
            bus.codec_bclk_i      = 1'b0;
            bus.codec_lrck_i      = lr;
            bus.dac_serial_data_i = f[31-i];
            if (i == en_at) bus.en_i = en_val;
            repeat (8) tick();
            bus.codec_bclk_i = 1'b1;
            repeat (8) tick();
        end
    endtask

    task automatic push_adc(input int id, input logic [23:0] w);
        adc_exp_t e;
        e.id   = id;
        e.bits = {8'h00, w};
        exp_adc_q.push_back(e);
    endtask

    task automatic push_dac(input logic [23:0] l, input logic [23:0] r);
        dac_pair_t p;
        p.l = l;
        p.r = r;
        exp_dac_q.push_back(p);
    endtask

    // DAC-side monitor and pulse counters
    always @(negedge clk) begin
        dac_pair_t p;
        if (bus.dac_valid_o) begin
            if (exp_dac_q.size() == 0) begin
                chk("dac_unexpected_valid", 32'(bus.dac_left_o), 32'hFFFF_FFFF);
            end else begin
                p = exp_dac_q.pop_front();
                chk("dac_left", 32'(bus.dac_left_o), 32'(p.l));
                chk("dac_right", 32'(bus.dac_right_o), 32'(p.r));
            end
        end
        if (bus.adc_req_o) n_req++;
        if (bus.frame_err_o) n_err++;
        if (quiet && bus.adc_serial_data_o) quiet_hi = 1'b1;
    end

    // ADC-side monitor: deserializes at master bclk rises, checks slot on next boundary
    logic        m_bclk_d = 1'b1;
    logic        m_lr_d = 1'b0;
    logic [31:0] m_sreg = '0;
    int          m_slot = 0;
    always @(negedge clk) begin
        adc_exp_t e;
        if (bus.codec_bclk_i && !m_bclk_d) begin
            if (bus.codec_lrck_i != m_lr_d) begin
                if (exp_adc_q.size() > 0 && exp_adc_q[0].id == 32'(m_slot)) begin
                    e = exp_adc_q.pop_front();
                    chk($sformatf("adc_slot%0d", m_slot), m_sreg, e.bits);
                end
                m_slot++;
                m_sreg = '0;
            end
            m_sreg = {m_sreg[30:0], bus.adc_serial_data_o};
            m_lr_d = bus.codec_lrck_i;
        end
        m_bclk_d = bus.codec_bclk_i;
    end

    initial begin
        bus.en_i              = 1'b0;
        bus.codec_bclk_i      = 1'b1;
        bus.codec_lrck_i      = 1'b0;
        bus.dac_serial_data_i = 1'b0;
        bus.adc_left_i        = '0;
        bus.adc_right_i       = '0;
        bus.adc_valid_i       = 1'b0;
        repeat (10) tick();
        chk("rst_sdo", 32'(bus.adc_serial_data_o), 0);
        chk("rst_req", 32'(bus.adc_req_o), 0);
        chk("rst_dval", 32'(bus.dac_valid_o), 0);
        chk("rst_ferr", 32'(bus.frame_err_o), 0);
        chk("rst_dac_left", 32'(bus.dac_left_o), 0);
        chk("rst_dac_right", 32'(bus.dac_right_o), 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Disabled: bclk runs, nothing comes out
        quiet = 1'b1;
        half_slot(1'b1, 24'h0F0F0F, 32, -1, 1'b0);   // slot 1
        half_slot(1'b0, 24'h00FF00, 32, -1, 1'b0);   // slot 2
        quiet = 1'b0;
        chk("idle_sdo_quiet", 32'(quiet_hi), 0);
        chk("idle_req_count", n_req, 0);
        chk("idle_err_count", n_err, 0);
        chk("idle_dac_left", 32'(bus.dac_left_o), 0);

        bus.adc_left_i  = 24'hABCDEF;
        bus.adc_right_i = 24'h123456;
        bus.adc_valid_i = 1'b1;
        tick();
        bus.adc_valid_i = 1'b0;
        bus.en_i        = 1'b1;

        push_adc(3, 24'hABCDEF);
        push_adc(4, 24'h123456);
        push_adc(5, 24'hABCDEF);
        push_adc(6, 24'h123456);
        push_dac(24'hFFF000, 24'hF0F0F0);
        half_slot(1'b1, 24'hFFF000, 32, -1, 1'b0);   // slot 3
        half_slot(1'b0, 24'hF0F0F0, 32, -1, 1'b0);   // slot 4
        push_dac(24'h123ABC, 24'h800000);
        half_slot(1'b1, 24'h123ABC, 32, -1, 1'b0);   // slot 5
        half_slot(1'b0, 24'h800000, 32, -1, 1'b0);   // slot 6
        chk("run_req_count", n_req, 2);
        chk("run_err_count", n_err, 0);

        // New ADC pair written right as the current one is consumed
        fork
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 1200 && !seen; k++) begin
                    @(negedge clk);
                    if (bus.adc_req_o) seen = 1'b1;
                end
                chk("coinc_req_seen", 32'(seen), 1);
                bus.adc_left_i  = 24'h5A5A5A;
                bus.adc_right_i = 24'hA5A5A5;
                bus.adc_valid_i = 1'b1;
                @(negedge clk);
                bus.adc_valid_i = 1'b0;
            end
        join_none
        push_adc(7, 24'hABCDEF);
        push_adc(8, 24'h123456);
        push_adc(9, 24'h5A5A5A);
        push_adc(10, 24'hA5A5A5);
        push_dac(24'hFFFFFF, 24'h000000);
        half_slot(1'b1, 24'hFFFFFF, 32, -1, 1'b0);   // slot 7
        half_slot(1'b0, 24'h000000, 32, -1, 1'b0);   // slot 8
        push_dac(24'h7FFFFF, 24'hC00003);
        half_slot(1'b1, 24'h7FFFFF, 32, -1, 1'b0);   // slot 9
        half_slot(1'b0, 24'hC00003, 32, -1, 1'b0);   // slot 10

        // Short left slot: error, no pair for this frame, resync on next 0->1
        half_slot(1'b1, 24'h111111, 31, -1, 1'b0);   // slot 11
        half_slot(1'b0, 24'h222222, 32, -1, 1'b0);   // slot 12
        push_adc(13, 24'h5A5A5A);
        push_adc(14, 24'hA5A5A5);
        push_adc(15, 24'h5A5A5A);
        push_dac(24'h0A0B0C, 24'h0D0E0F);
        half_slot(1'b1, 24'h0A0B0C, 32, -1, 1'b0);   // slot 13
        half_slot(1'b0, 24'h0D0E0F, 32, -1, 1'b0);   // slot 14
        chk("err_count", n_err, 1);

        // Disable mid-slot, re-enable three frames later
        half_slot(1'b1, 24'h999999, 32, -1, 1'b0);   // slot 15
        half_slot(1'b0, 24'h888888, 32, 16, 1'b0);   // slot 16
        quiet = 1'b1;
        half_slot(1'b1, 24'h777777, 32, -1, 1'b0);   // slot 17
        half_slot(1'b0, 24'h666666, 32, -1, 1'b0);   // slot 18
        half_slot(1'b1, 24'h555555, 32, -1, 1'b0);   // slot 19
        half_slot(1'b0, 24'h444444, 32, -1, 1'b0);   // slot 20
        half_slot(1'b1, 24'h333333, 32, -1, 1'b0);   // slot 21
        half_slot(1'b0, 24'h222222, 32, 16, 1'b1);   // slot 22
        quiet = 1'b0;
        chk("dis_sdo_quiet", 32'(quiet_hi), 0);
        chk("dis_dac_left_hold", 32'(bus.dac_left_o), 32'h0A0B0C);
        chk("dis_dac_right_hold", 32'(bus.dac_right_o), 32'h0D0E0F);
        chk("dis_err_count", n_err, 1);

        push_adc(23, 24'h5A5A5A);
        push_adc(24, 24'hA5A5A5);
        push_adc(25, 24'h5A5A5A);
        push_adc(26, 24'hA5A5A5);
        push_dac(24'h13579B, 24'h2468AC);
        half_slot(1'b1, 24'h13579B, 32, -1, 1'b0);   // slot 23
        half_slot(1'b0, 24'h2468AC, 32, -1, 1'b0);   // slot 24
        push_dac(24'h555555, 24'hAAAAAA);
        half_slot(1'b1, 24'h555555, 32, -1, 1'b0);   // slot 25
        half_slot(1'b0, 24'hAAAAAA, 32, -1, 1'b0);   // slot 26
        half_slot(1'b1, 24'h000000, 32, -1, 1'b0);   // slot 27
        repeat (8) tick();

        chk("final_slot_count", slot_no, 27);
        chk("final_dac_queue_empty", exp_dac_q.size(), 0);
        chk("final_adc_queue_empty", exp_adc_q.size(), 0);
        chk("final_req_count", n_req, 10);
        chk("final_err_count", n_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
